// File: rtl/shmem_arbiter_pkg.sv
// rtl/shmem_arbiter_pkg.sv - shared types for the shared-memory arbiter
package shmem_arbiter_pkg;

  localparam int SIMD_W    = 128;
  localparam int ADDR_BITS = 32;

  typedef logic [ADDR_BITS-1:0] addr_t;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_RD0,
    ARB_RD1,
    ARB_WR
  } arb_state_t;

endpackage

// File: rtl/shmem_arbiter_rr_pick.sv
// rtl/shmem_arbiter_rr_pick.sv - combinational round-robin requester pick
module shmem_arbiter_rr_pick #(
  parameter int NUM_PROCS = 4,
  parameter int IDX_W     = 2
) (
  input  logic [NUM_PROCS-1:0] req_i,
  input  logic [NUM_PROCS-1:0] mask_i,
  input  logic [IDX_W-1:0]     rr_ptr_i,
  output logic                 valid_o,
  output logic [IDX_W-1:0]     winner_o
);

  logic [NUM_PROCS-1:0] cand;

  assign cand = req_i & ~mask_i;

  // Scan from the farthest offset down so the requester closest to rr_ptr wins last.
  always_comb begin : pick_scan
    int idx;
    idx      = 0;
    valid_o  = 1'b0;
    winner_o = '0;
    for (int i = NUM_PROCS - 1; i >= 0; i--) begin
      idx = (int'(rr_ptr_i) + i) % NUM_PROCS;
      if (cand[idx]) begin
        valid_o  = 1'b1;
        winner_o = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/shmem_arbiter.sv
// rtl/shmem_arbiter.sv - round-robin owner of the single shared-memory port
module shmem_arbiter
  import shmem_arbiter_pkg::*;
#(
  parameter int NUM_PROCS = 4,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = SIMD_W,
  localparam int IDX_W    = $clog2(NUM_PROCS)
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic [NUM_PROCS-1:0]      i_req_rd,
  input  logic [NUM_PROCS-1:0]      i_req_wr,
  input  logic [NUM_PROCS*ADDR_W-1:0] i_addr,
  input  logic [NUM_PROCS*DATA_W-1:0] i_wr_data,
  input  logic [NUM_PROCS*3-1:0]    i_wr_size,
  output logic [NUM_PROCS-1:0]      o_grant_rd,
  output logic [NUM_PROCS-1:0]      o_grant_wr,
  output logic [DATA_W-1:0]         o_rd_data,
  output logic [ADDR_W-1:0]         o_mem_addr,
  output logic                      o_mem_wr_en,
  output logic [DATA_W-1:0]         o_mem_wr_data,
  output logic [2:0]                o_mem_wr_size,
  input  logic [DATA_W-1:0]         i_mem_rd_data,
  output logic                      o_busy,
  output logic [IDX_W-1:0]          o_owner,
  output logic                      o_err
);

  arb_state_t           state_q, state_d;
  logic [IDX_W-1:0]     owner_q, owner_d;
  logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic                 err_q, err_d;

  logic [NUM_PROCS-1:0] req;
  logic [NUM_PROCS-1:0] mask;
  logic [NUM_PROCS-1:0] owner_onehot;
  logic                 pick_valid;
  logic [IDX_W-1:0]     pick_winner;

  assign req          = i_req_rd | i_req_wr;
  assign owner_onehot = NUM_PROCS'(1) << owner_q;

  // The owner's request is stale while it finishes, so hide it from the pick.
  always_comb begin
    mask = '0;
    if (state_q == ARB_RD1 || state_q == ARB_WR) begin
      mask = owner_onehot;
    end
  end

  shmem_arbiter_rr_pick #(
    .NUM_PROCS (NUM_PROCS),
    .IDX_W     (IDX_W)
  ) u_rr_pick (
    .req_i    (req),
    .mask_i   (mask),
    .rr_ptr_i (rr_ptr_q),
    .valid_o  (pick_valid),
    .winner_o (pick_winner)
  );

  // Next-state: RD0 always runs into RD1; every other state re-arbitrates.
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    err_d    = err_q | (|(i_req_rd & i_req_wr));
    if (state_q == ARB_RD0) begin
      state_d = ARB_RD1;
    end else if (pick_valid) begin
      owner_d  = pick_winner;
      rr_ptr_d = (pick_winner == IDX_W'(NUM_PROCS - 1)) ? '0 : pick_winner + 1'b1;
      state_d  = i_req_wr[pick_winner] ? ARB_WR : ARB_RD0;
    end else begin
      state_d = ARB_IDLE;
    end
  end

  // State, ownership and sticky error registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= ARB_IDLE;
      owner_q  <= '0;
      rr_ptr_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
      err_q    <= err_d;
    end
  end

  // Grants and the write strobe are suppressed while reset is applied so an aborted transaction never fires.
  assign o_grant_rd    = (state_q == ARB_RD0 && !i_rst) ? owner_onehot : '0;
  assign o_grant_wr    = (state_q == ARB_WR  && !i_rst) ? owner_onehot : '0;
  assign o_mem_wr_en   = (state_q == ARB_WR) && !i_rst;
  assign o_mem_addr    = (state_q == ARB_IDLE) ? '0 : i_addr[int'(owner_q)*ADDR_W +: ADDR_W];
  assign o_mem_wr_data = i_wr_data[int'(owner_q)*DATA_W +: DATA_W];
  assign o_mem_wr_size = i_wr_size[int'(owner_q)*3 +: 3];
  assign o_rd_data     = i_mem_rd_data;
  assign o_busy        = (state_q != ARB_IDLE);
  assign o_owner       = owner_q;
  assign o_err         = err_q;

endmodule
